// File: rtl/fle_ccff_loader.sv
// fle_ccff_loader: streams host bytes MSB-first into a serial configuration
// chain (CCFF), then optionally recirculates the chain once and compares the
// parity of what comes out of the tail against the parity of what was loaded.
module fle_ccff_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int BYTE_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int HW = $clog2(BYTE_W + 1);
  localparam int SW = ((CW > HW) ? CW : HW) + 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     bits_sent;   // bits pushed into the chain this load
  logic [CW-1:0]     vcnt;        // recirculation cycles completed
  logic [BYTE_W-1:0] hold;
  logic              hold_v;
  logic [HW-1:0]     hold_cnt;    // bits still pending in hold
  logic              ven_q;
  logic              load_par;
  logic              tail_par;
  logic              err_q;

  logic [HW-1:0]     bits_in_hold;
  logic [SW-1:0]     fill;
  logic              room;
  logic              last_bit;
  logic              vlast;
  logic              xfer;

  // Bits committed so far; a new byte is only taken while the chain has room.
  assign bits_in_hold = hold_v ? hold_cnt : '0;
  assign fill         = SW'(bits_sent) + SW'(bits_in_hold);
  assign room         = (fill < SW'(CHAIN_LEN));
  assign last_bit     = (state == S_LOAD) && hold_v && (bits_sent == LAST);
  assign vlast        = (state == S_VERIFY) && (vcnt == LAST);
  assign xfer         = byte_valid && byte_ready;
  assign err          = err_q;

  // State register
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state: load ends on the edge that pushes the last bit
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   if (last_bit) state_nx = ven_q ? S_VERIFY : S_DONE;
      S_VERIFY: if (vlast) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs: head/shift qualified by state; verify recirculates tail to head
  always_comb begin
    byte_ready    = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_LOAD: begin
        busy          = 1'b1;
        byte_ready    = !hold_v && room;
        ccff_shift_en = hold_v;
        ccff_head     = hold_v & hold[BYTE_W-1];
      end
      S_VERIFY: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: hold register, counters, parities and the sticky error flag
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      bits_sent <= '0;
      vcnt      <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      hold_cnt  <= '0;
      ven_q     <= 1'b0;
      load_par  <= 1'b0;
      tail_par  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ven_q     <= verify_en;
          err_q     <= 1'b0;
          bits_sent <= '0;
          vcnt      <= '0;
          load_par  <= 1'b0;
          tail_par  <= 1'b0;
          hold_v    <= 1'b0;
        end
        S_LOAD: begin
          if (hold_v) begin
            hold      <= hold << 1;
            hold_cnt  <= hold_cnt - HW'(1);
            bits_sent <= bits_sent + CW'(1);
            load_par  <= load_par ^ hold[BYTE_W-1];
            // Drop leftover bits of a final partial byte
            if (hold_cnt == HW'(1) || bits_sent == LAST) hold_v <= 1'b0;
          end else if (xfer) begin
            hold     <= byte_in;
            hold_cnt <= HW'(BYTE_W);
            hold_v   <= 1'b1;
          end
        end
        S_VERIFY: begin
          vcnt     <= vcnt + CW'(1);
          tail_par <= tail_par ^ ccff_tail;
          if (vlast) err_q <= ((tail_par ^ ccff_tail) != load_par);
        end
        default: ;
      endcase
    end
  end

endmodule
